sample_and_hold_tdm: RTL and testbench

Multi-channel, time-division-multiplexed successor to the single-stream sample-and-hold. One channel arrives per clock in fixed order 0..N_CHAN-1. Over a window of PERIOD frames the block reduces each channel by the selected mode (sample, max-hold or accumulate), then holds the per-channel results and replays them in the same TDM order. It sits after spectrum/power blocks, ahead of slow readout and monitoring registers.

---
 rtl/sample_and_hold_tdm_pkg.sv | 19 +
 rtl/sample_and_hold_tdm_frame_counter.sv | 47 ++++
 rtl/sample_and_hold_tdm.sv | 107 ++++++++++
 tb/tb_sample_and_hold_tdm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_and_hold_tdm_pkg.sv
// Shared definitions for the TDM sample-and-hold.
//   MODE_*  : reduction mode encodings (3 is reserved and behaves as sample)
//   clog2() : ceiling log2, used to size OUT_W and the channel/frame indices
package sample_and_hold_tdm_pkg;

   localparam logic [1:0] MODE_SAMPLE = 2'd0;
   localparam logic [1:0] MODE_MAX    = 2'd1;
   localparam logic [1:0] MODE_ACC    = 2'd2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sample_and_hold_tdm_frame_counter.sv
// TDM position counter: channel index inside a frame and frame index inside
// a window.
//   clk, rst_n : clock, asynchronous active-low reset
//   sync       : restart at channel 0 / frame 0 on the next edge
//   chan, frm  : current channel and frame
//   first      : channel 0 of frame 0 (window start)
//   last_frm   : current frame is the last of the window
module tdm_frame_counter
   import sample_and_hold_tdm_pkg::*;
#(
   parameter int N_CHAN    = 4,
   parameter int PERIOD    = 128,
   parameter int CHAN_BITS = 2,
   parameter int FRM_BITS  = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sync,
   output logic [CHAN_BITS-1:0] chan,
   output logic [FRM_BITS-1:0]  frm,
   output logic                 first,
   output logic                 last_frm
);

   localparam logic [CHAN_BITS-1:0] CHAN_LAST = CHAN_BITS'(N_CHAN - 1);
   localparam logic [FRM_BITS-1:0]  FRM_LAST  = FRM_BITS'(PERIOD - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan <= '0;
         frm  <= '0;
      end else if (sync) begin
         // sync overrides wrap and any window in progress
         chan <= '0;
         frm  <= '0;
      end else if (chan == CHAN_LAST) begin
         chan <= '0;
         frm  <= (frm == FRM_LAST) ? '0 : frm + 1'b1;
      end else begin
         chan <= chan + 1'b1;
      end
   end

   assign first    = (chan == '0) && (frm == '0);
   assign last_frm = (frm == FRM_LAST);

endmodule

// File: rtl/sample_and_hold_tdm.sv
// Multi-channel TDM sample-and-hold. Each channel is reduced over a window
// of PERIOD frames (sample, max-hold or accumulate); results are held per
// channel and replayed in TDM order.
//   clk, rst_n : clock, asynchronous active-low reset
//   sync       : frame marker, next cycle is channel 0 of frame 0
//   mode       : 0 sample, 1 max-hold, 2 accumulate, 3 reserved (sample)
//   din        : sample of the current channel
//   dout       : held (or freshly completed) result for dout_chan
//   dout_chan  : channel index of dout
//   dout_new   : dout is a result completed in this window
module sample_and_hold_tdm
   import sample_and_hold_tdm_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int N_CHAN = 4,
   parameter int PERIOD = 128,
   parameter int SIGNED = 0,
   localparam int OUT_W     = WIDTH + clog2(PERIOD),
   localparam int CHAN_BITS = (N_CHAN > 1) ? clog2(N_CHAN) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sync,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     din,
   output logic [OUT_W-1:0]     dout,
   output logic [CHAN_BITS-1:0] dout_chan,
   output logic                 dout_new
);

   localparam int FRM_BITS = clog2(PERIOD);
   localparam int PAD      = OUT_W - WIDTH;

   logic [CHAN_BITS-1:0] chan;
   logic [FRM_BITS-1:0]  frm;
   logic                 first;
   logic                 last_frm;

   logic [1:0]           mode_q;
   logic [OUT_W-1:0]     acc  [N_CHAN];
   logic [OUT_W-1:0]     hold [N_CHAN];

   logic [OUT_W-1:0]     ext_din;
   logic [OUT_W-1:0]     acc_cur;
   logic [OUT_W-1:0]     res;
   logic                 din_gt;

   tdm_frame_counter #(
      .N_CHAN    (N_CHAN),
      .PERIOD    (PERIOD),
      .CHAN_BITS (CHAN_BITS),
      .FRM_BITS  (FRM_BITS)
   ) u_frame_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync     (sync),
      .chan     (chan),
      .frm      (frm),
      .first    (first),
      .last_frm (last_frm)
   );

   // res is the channel's updated working value; on the last frame it is
   // also the window result, forwarded straight to dout.
   always_comb begin
      if (SIGNED != 0) ext_din = {{PAD{din[WIDTH-1]}}, din};
      else             ext_din = {{PAD{1'b0}}, din};

      acc_cur = acc[chan];

      if (SIGNED != 0) din_gt = ($signed(ext_din) > $signed(acc_cur));
      else             din_gt = (ext_din > acc_cur);

      res = acc_cur;
      if (frm == '0) begin
         res = ext_din;
      end else begin
         case (mode_q)
            MODE_MAX: res = din_gt ? ext_din : acc_cur;
            MODE_ACC: res = acc_cur + ext_din;
            default:  res = acc_cur;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_SAMPLE;
         for (int i = 0; i < N_CHAN; i++) begin
            acc[i]  <= '0;
            hold[i] <= '0;
         end
         dout      <= '0;
         dout_chan <= '0;
         dout_new  <= 1'b0;
      end else begin
         // frame 0 ignores the mode, so latching here still governs frames 1..
         if (first) mode_q <= mode;
         acc[chan] <= res;
         if (last_frm) hold[chan] <= res;
         dout      <= last_frm ? res : hold[chan];
         dout_chan <= chan;
         dout_new  <= last_frm;
      end
   end

endmodule

// File: tb/tb_sample_and_hold_tdm.sv
module tb_sample_and_hold_tdm;
   localparam int WIDTH  = 8;
   localparam int N      = 4;
   localparam int P      = 4;
   localparam int OUT_W  = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sync;
   logic [1:0]       mode;
   logic [WIDTH-1:0] din;
   logic [OUT_W-1:0] dout_u, dout_s;
   logic [1:0]       chan_u, chan_s;
   logic             new_u, new_s;

   always #5 clk = ~clk;

   sample_and_hold_tdm #(.WIDTH(WIDTH), .N_CHAN(N), .PERIOD(P), .SIGNED(0)) dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .mode(mode), .din(din),
      .dout(dout_u), .dout_chan(chan_u), .dout_new(new_u));

   sample_and_hold_tdm #(.WIDTH(WIDTH), .N_CHAN(N), .PERIOD(P), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .sync(sync), .mode(mode), .din(din),
      .dout(dout_s), .dout_chan(chan_s), .dout_new(new_s));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: keeps every sample of the window, reduces at the end
   int m_c, m_f, win_mode;
   int smp    [N][P];
   int hold_u [N];
   int hold_s [N];
   int exp_u, exp_s, exp_c, exp_n;

   bit spec_on;
   bit spec_sel;
   int spec_exp [N];

   function automatic int sval(input int v, input bit sgn);
      return (sgn && v > 127) ? v - 256 : v;
   endfunction

   function automatic int reduce(input int c, input bit sgn);
      int r, v;
      r = sval(smp[c][0], sgn);
      for (int f = 1; f < P; f++) begin
         v = sval(smp[c][f], sgn);
         if (win_mode == 1 && v > r) r = v;
         else if (win_mode == 2) r = r + v;
      end
      return r & 'h3FF;
   endfunction

   task automatic model_reset();
      m_c = 0; m_f = 0; win_mode = 0;
      for (int c = 0; c < N; c++) begin
         hold_u[c] = 0; hold_s[c] = 0;
         for (int f = 0; f < P; f++) smp[c][f] = 0;
      end
   endtask

   task automatic model_update(input bit s, input logic [1:0] m, input logic [7:0] d);
      int c, f;
      c = m_c; f = m_f;
      if (c == 0 && f == 0) win_mode = (m == 2'd3) ? 0 : int'(m);
      smp[c][f] = int'(d);
      exp_c = c;
      exp_n = 0;
      if (f == P - 1) begin
         hold_u[c] = reduce(c, 1'b0);
         hold_s[c] = reduce(c, 1'b1);
         exp_n = 1;
      end
      exp_u = hold_u[c];
      exp_s = hold_s[c];
      if (s) begin
         m_c = 0; m_f = 0;
      end else if (m_c == N - 1) begin
         m_c = 0;
         m_f = (m_f == P - 1) ? 0 : m_f + 1;
      end else begin
         m_c = m_c + 1;
      end
   endtask

   task automatic step(input bit s, input logic [1:0] m, input logic [7:0] d);
      sync = s; mode = m; din = d;
      @(posedge clk); #1;
      model_update(s, m, d);
      chk("dout_u", 32'(dout_u), 32'(exp_u));
      chk("dout_s", 32'(dout_s), 32'(exp_s));
      chk("chan_u", 32'(chan_u), 32'(exp_c));
      chk("chan_s", 32'(chan_s), 32'(exp_c));
      chk("new_u",  32'(new_u),  32'(exp_n));
      chk("new_s",  32'(new_s),  32'(exp_n));
      if (spec_on && exp_n == 1)
         chk("spec_val", spec_sel ? 32'(dout_s) : 32'(dout_u), 32'(spec_exp[exp_c]));
   endtask

   function automatic logic [7:0] pat(input int id, input int c, input int f);
      case (id)
         0:       return 8'(16 * f + c);
         1:       return (f == 2) ? 8'(200 + c) : 8'(c);
         2:       return (f < 2) ? 8'hFB : 8'hFD;
         3:       return 8'd255;
         4:       return 8'd10;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // sync, then one full window; first cycle uses m0, the rest m1
   task automatic run_win(input int id, input logic [1:0] m0, input logic [1:0] m1);
      step(1'b1, m0, 8'd0);
      for (int f = 0; f < P; f++)
         for (int c = 0; c < N; c++)
            step(1'b0, (c == 0 && f == 0) ? m0 : m1, pat(id, c, f));
   endtask

   initial begin
      rst_n = 1'b0; sync = 1'b0; mode = 2'd0; din = '0;
      spec_on = 1'b0; spec_sel = 1'b0;
      model_reset();
      #3;
      chk("rst_dout", 32'(dout_u), 32'd0);
      chk("rst_chan", 32'(chan_u), 32'd0);
      chk("rst_new",  32'(new_u),  32'd0);
      #9 rst_n = 1'b1;

      // free-running start without sync
      for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 8'($urandom_range(0, 255)));

      // asynchronous reset mid-window, right after a dout_new cycle
      step(1'b1, 2'd2, 8'd0);
      for (int i = 0; i < 15; i++) step(1'b0, 2'd2, 8'($urandom_range(0, 255)));
      #1 rst_n = 1'b0;
      #1;
      chk("arst_dout", 32'(dout_u), 32'd0);
      chk("arst_chan", 32'(chan_u), 32'd0);
      chk("arst_new",  32'(new_u),  32'd0);
      chk("arst_dout_s", 32'(dout_s), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0, 2'd1, 8'($urandom_range(0, 255)));

      // mode 0
      spec_on = 1'b1; spec_sel = 1'b0;
      for (int c = 0; c < N; c++) spec_exp[c] = c;
      run_win(0, 2'd0, 2'd0);
      spec_on = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 8'($urandom_range(0, 255)));

      // mode 1, unsigned then signed
      spec_on = 1'b1; spec_sel = 1'b0;
      for (int c = 0; c < N; c++) spec_exp[c] = 200 + c;
      run_win(1, 2'd1, 2'd1);
      spec_sel = 1'b1;
      for (int c = 0; c < N; c++) spec_exp[c] = 'h3FD;
      run_win(2, 2'd1, 2'd1);

      // mode 2 at full scale
      spec_sel = 1'b0;
      for (int c = 0; c < N; c++) spec_exp[c] = 1020;
      run_win(3, 2'd2, 2'd2);
      spec_on = 1'b0;

      // sync at frame 2 discards the partial window
      run_win(5, 2'd2, 2'd2);
      step(1'b1, 2'd1, 8'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 2'd1, 8'($urandom_range(0, 255)));
      step(1'b1, 2'd1, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 20; i++) step(1'b0, 2'd1, 8'($urandom_range(0, 255)));

      // sync during the last frame still commits that cycle
      step(1'b1, 2'd2, 8'd0);
      for (int i = 0; i < 13; i++) step(1'b0, 2'd2, 8'($urandom_range(0, 255)));
      step(1'b1, 2'd2, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 8'($urandom_range(0, 255)));

      // mode change 2 -> 1 at frame 1
      spec_on = 1'b1; spec_sel = 1'b0;
      for (int c = 0; c < N; c++) spec_exp[c] = 40;
      run_win(4, 2'd2, 2'd1);
      for (int c = 0; c < N; c++) spec_exp[c] = 10;
      for (int i = 0; i < N * P; i++) step(1'b0, 2'd1, 8'd10);
      spec_on = 1'b0;

      // random soak
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         step($urandom_range(0, 49) == 0, mode, 8'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
